serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 6 +
 rtl/serial_adder_if.sv | 23 ++
 rtl/half_adder.sv | 10 +
 rtl/serial_adder_full_adder.sv | 17 +
 rtl/serial_adder.sv | 112 +++++++++++
 tb/tb_serial_adder.sv | 206 ++++++++++++++++++++
 6 files changed

// File: rtl/serial_adder_pkg.sv
// Shared state encoding for the bit-serial adder.
package serial_adder_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
interface serial_adder_if #(parameter int WIDTH = 4);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/half_adder.sv
// One-bit half adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder composed of two half adders and an OR of their carries.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  logic s0_s;
  logic c0_s;
  logic c1_s;

  half_adder u_ha0 (.a(a),    .b(b),   .sum(s0_s), .carry(c0_s));
  half_adder u_ha1 (.a(s0_s), .b(cin), .sum(sum),  .carry(c1_s));

  assign carry = c0_s | c1_s;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB-first, one bit per clock, with input and
// output valid/ready handshakes.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);
  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_shift_s;
  logic             carry_r;
  logic             cout_r;
  logic [CW-1:0]    cnt_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             fa_sum_s;
  logic             fa_carry_s;

  full_adder u_fa (
    .a    (a_r[0]),
    .b    (b_r[0]),
    .cin  (carry_r),
    .sum  (fa_sum_s),
    .carry(fa_carry_s)
  );

  // Next-state decode and the sum shift with the new bit entering at the MSB.
  always_comb begin
    state_s     = state_r;
    sum_shift_s = sum_r >> 1;
    sum_shift_s[WIDTH-1] = fa_sum_s;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) state_s = RUN;
        else              state_s = IDLE;
      end
      RUN: begin
        if (cnt_r == LAST) state_s = DONE;
        else               state_s = RUN;
      end
      DONE: begin
        if (bus.out_ready) state_s = IDLE;
        else               state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register, datapath and registered handshake flags; reset wins everywhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      carry_r     <= 1'b0;
      cout_r      <= 1'b0;
      cnt_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            carry_r <= bus.cin;
            cnt_r   <= '0;
          end
        end
        RUN: begin
          a_r     <= a_r >> 1;
          b_r     <= b_r >> 1;
          carry_r <= fa_carry_s;
          sum_r   <= sum_shift_s;
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == LAST) cout_r <= fa_carry_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed scenarios plus an exhaustive
// sweep against an arithmetic reference ({cout,sum} == a + b + cin).
module tb_serial_adder;
  localparam int W     = 4;
  localparam int BOUND = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_adder_if #(.WIDTH(W)) bus ();
  serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int r;
    r = int'(x) + int'(y) + int'(c);
    return (W+1)'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted; ok=0 if in_ready never came.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, output bit ok);
    int g = 0;
    bus.a = ta; bus.b = tb; bus.cin = tc; bus.in_valid = 1'b1;
    while (!bus.in_ready && g < BOUND) begin tick(); g++; end
    tick();
    bus.in_valid = 1'b0;
    ok = (g < BOUND);
  endtask

  // Count edges until out_valid; optionally toggle out_ready randomly meanwhile.
  task automatic wait_done(input bit rand_ready, output int n);
    n = 0;
    while (!bus.out_valid && n < BOUND) begin
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (rand_ready) bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.cout} !== 4'b1000 || bus.sum !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset: got in_ready=%b out_valid=%b busy=%b cout=%b sum=%b, required 1 0 0 0 0000",
               bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.sum);
    end
  endtask

  task automatic test_basic();
    bit ok; int n;
    bus.out_ready = 1'b1;
    send(4'b0011, 4'b0101, 1'b0, ok);
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || !ok) begin
      n_fail++;
      $display("FAIL basic_accept: got in_ready=%b busy=%b ok=%0d, required 0 1 1", bus.in_ready, bus.busy, ok);
    end
    wait_done(1'b0, n);
    n_checks++;
    if (n !== W) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d cycles, required %0d", n, W);
    end
    n_checks++;
    if ({bus.cout, bus.sum} !== 5'b01000) begin
      n_fail++;
      $display("FAIL basic_result: got %b_%b, required 0_1000", bus.cout, bus.sum);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_release: got out_valid=%b in_ready=%b busy=%b, required 0 1 0",
               bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_carry();
    logic [W-1:0] av [2] = '{4'b1111, 4'b0000};
    logic [W-1:0] bv [2] = '{4'b0001, 4'b0000};
    logic         cv [2] = '{1'b0, 1'b1};
    bit ok; int n;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(av[i], bv[i], cv[i], ok);
      wait_done(1'b0, n);
      n_checks++;
      if ({bus.cout, bus.sum} !== model(av[i], bv[i], cv[i]) || n !== W) begin
        n_fail++;
        $display("FAIL carry_%0d: got %b_%b after %0d cycles, required %b after %0d",
                 i, bus.cout, bus.sum, n, model(av[i], bv[i], cv[i]), W);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit ok; int n;
    bus.out_ready = 1'b0;
    send(4'b1010, 4'b0111, 1'b1, ok);
    wait_done(1'b0, n);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || {bus.cout, bus.sum} !== model(4'b1010, 4'b0111, 1'b1)) begin
        n_fail++;
        $display("FAIL stall_%0d: got out_valid=%b result=%b_%b, required 1 %b",
                 k, bus.out_valid, bus.cout, bus.sum, model(4'b1010, 4'b0111, 1'b1));
      end
    end
    bus.out_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: got out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_ignore_inputs();
    bit ok; int n;
    bus.out_ready = 1'b0;
    send(4'b0011, 4'b0101, 1'b0, ok);
    bus.a = 4'b1111; bus.b = 4'b1111; bus.cin = 1'b1; bus.in_valid = 1'b1;
    wait_done(1'b0, n);
    tick(); tick();
    n_checks++;
    if ({bus.cout, bus.sum} !== 5'b01000 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_inputs: got out_valid=%b result=%b_%b, required 1 0_1000",
               bus.out_valid, bus.cout, bus.sum);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_mid_reset();
    bit ok; int n;
    bus.out_ready = 1'b1;
    send(4'b1111, 4'b1111, 1'b1, ok);
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.cout} !== 4'b1000 || bus.sum !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset: got in_ready=%b out_valid=%b busy=%b cout=%b sum=%b, required 1 0 0 0 0000",
               bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.sum);
    end
    send(4'b0110, 4'b0011, 1'b0, ok);
    wait_done(1'b0, n);
    n_checks++;
    if ({bus.cout, bus.sum} !== 5'b01001) begin
      n_fail++;
      $display("FAIL post_reset_op: got %b_%b, required 0_1001", bus.cout, bus.sum);
    end
    tick();
  endtask

  task automatic test_exhaustive();
    bit ok; int n;
    logic [8:0] v;
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      send(v[3:0], v[7:4], v[8], ok);
      wait_done(1'b1, n);
      n_checks++;
      if (!ok || n >= BOUND || {bus.cout, bus.sum} !== model(v[3:0], v[7:4], v[8])) begin
        n_fail++;
        $display("FAIL exhaustive a=%b b=%b cin=%b: got %b_%b (ok=%0d wait=%0d), required %b",
                 v[3:0], v[7:4], v[8], bus.cout, bus.sum, ok, n, model(v[3:0], v[7:4], v[8]));
      end
      repeat ($urandom_range(0, 2)) tick();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_ignore_inputs();
    test_mid_reset();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
